// File: rtl/i3c_controller_sdr_fsm_if.sv
// ---------------------------------------------------------------------------
// i3c_controller_sdr_fsm_if
//   Bundles the command, response, data-FIFO and bus-primitive signals of the
//   I3C controller SDR sequencer. Signal suffixes (_i/_o) are named from the
//   controller's point of view.
//
//   modport master : the sequencer itself (i3c_controller_sdr_fsm)
//   modport slave  : everything around it (command queue, FIFOs, bus layer)
//
//   Groups:
//     cmd_*       command handshake plus address/direction/length/broadcast
//     tx_fifo_*   write-data source (pop side)
//     rx_fifo_*   read-data sink (push side)
//     bus_*       START/STOP and bit/byte TX/RX primitive requests + dones
//     resp_*      status/count response handshake
//     idle_o      sequencer sits in IDLE
// ---------------------------------------------------------------------------
interface i3c_controller_sdr_fsm_if #(
  parameter int DataWidth = 8,
  parameter int LenWidth  = 8
);
  logic                 cmd_valid_i;
  logic                 cmd_ready_o;
  logic [6:0]           cmd_addr_i;
  logic                 cmd_rnw_i;
  logic [LenWidth-1:0]  cmd_len_i;
  logic                 cmd_bcast_i;

  logic                 tx_fifo_rvalid_i;
  logic                 tx_fifo_rready_o;
  logic [DataWidth-1:0] tx_fifo_rdata_i;

  logic                 rx_fifo_wvalid_o;
  logic                 rx_fifo_wready_i;
  logic [DataWidth-1:0] rx_fifo_wdata_o;

  logic                 bus_start_req_o;
  logic                 bus_start_done_i;
  logic                 bus_stop_req_o;
  logic                 bus_stop_done_i;
  logic                 bus_tx_req_byte_o;
  logic                 bus_tx_req_bit_o;
  logic [DataWidth-1:0] bus_tx_req_value_o;
  logic                 bus_tx_done_i;
  logic                 bus_rx_req_byte_o;
  logic                 bus_rx_req_bit_o;
  logic                 bus_rx_done_i;
  logic [DataWidth-1:0] bus_rx_data_i;

  logic                 resp_valid_o;
  logic                 resp_ready_i;
  logic [1:0]           resp_status_o;
  logic [LenWidth-1:0]  resp_count_o;

  logic                 idle_o;

  modport master (
    input  cmd_valid_i, cmd_addr_i, cmd_rnw_i, cmd_len_i, cmd_bcast_i,
    output cmd_ready_o,
    input  tx_fifo_rvalid_i, tx_fifo_rdata_i,
    output tx_fifo_rready_o,
    input  rx_fifo_wready_i,
    output rx_fifo_wvalid_o, rx_fifo_wdata_o,
    input  bus_start_done_i, bus_stop_done_i, bus_tx_done_i,
    input  bus_rx_done_i, bus_rx_data_i,
    output bus_start_req_o, bus_stop_req_o,
    output bus_tx_req_byte_o, bus_tx_req_bit_o, bus_tx_req_value_o,
    output bus_rx_req_byte_o, bus_rx_req_bit_o,
    input  resp_ready_i,
    output resp_valid_o, resp_status_o, resp_count_o,
    output idle_o
  );

  modport slave (
    output cmd_valid_i, cmd_addr_i, cmd_rnw_i, cmd_len_i, cmd_bcast_i,
    input  cmd_ready_o,
    output tx_fifo_rvalid_i, tx_fifo_rdata_i,
    input  tx_fifo_rready_o,
    output rx_fifo_wready_i,
    input  rx_fifo_wvalid_o, rx_fifo_wdata_o,
    output bus_start_done_i, bus_stop_done_i, bus_tx_done_i,
    output bus_rx_done_i, bus_rx_data_i,
    input  bus_start_req_o, bus_stop_req_o,
    input  bus_tx_req_byte_o, bus_tx_req_bit_o, bus_tx_req_value_o,
    input  bus_rx_req_byte_o, bus_rx_req_bit_o,
    output resp_ready_i,
    input  resp_valid_o, resp_status_o, resp_count_o,
    input  idle_o
  );
endinterface

// File: rtl/i3c_controller_sdr_fsm.sv
// ---------------------------------------------------------------------------
// i3c_controller_sdr_fsm
//   Controller-side SDR private-transfer sequencer. Accepts one command
//   (address, direction, byte count), drives START, address+RnW, address ACK,
//   data bytes with T-bits and STOP through the bus primitive layer, then
//   returns a status/count response.
//
//   Ports:
//     clk_i   clock
//     rst_ni  asynchronous active-low reset (no STOP, no response issued)
//     bus     i3c_controller_sdr_fsm_if.master: command, TX/RX FIFO,
//             bus primitive and response signals
//
//   Optional feature macro: I3C_CTRL_BCAST_HDR_EN
//     defined   -> cmd_bcast_i=1 inserts the 7'h7E header, its ACK check and a
//                  repeated START before the address (header NACK = status 3)
//     undefined -> cmd_bcast_i is ignored and status 3 never occurs
//
//   Response status: 0 OK, 1 ADDR_NACK, 2 EARLY_END, 3 BCAST_NACK
// ---------------------------------------------------------------------------
module i3c_controller_sdr_fsm #(
  parameter int DataWidth = 8,
  parameter int LenWidth  = 8
) (
  input logic                       clk_i,
  input logic                       rst_ni,
  i3c_controller_sdr_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_BCAST, ST_BCAST_ACK, ST_RSTART, ST_ADDR, ST_ADDR_ACK,
    ST_WDATA, ST_WPAR, ST_RDATA, ST_RPUSH, ST_RTBIT, ST_STOP, ST_RESP
  } stateT;

  localparam logic [1:0] STATUS_OK         = 2'd0;
  localparam logic [1:0] STATUS_ADDR_NACK  = 2'd1;
  localparam logic [1:0] STATUS_EARLY_END  = 2'd2;
  localparam logic [1:0] STATUS_BCAST_NACK = 2'd3;

  stateT                r_state;
  logic [6:0]           r_addr;
  logic                 r_rnw;
  logic [LenWidth-1:0]  r_len;
  logic                 r_bcast;
  logic                 r_tbit;
  logic [LenWidth-1:0]  r_count;
  logic [1:0]           r_status;

  logic                 r_cmdReady;
  logic                 r_idle;
  logic                 r_txFifoRready;
  logic                 r_rxFifoWvalid;
  logic [DataWidth-1:0] r_rxFifoWdata;
  logic                 r_startReq;
  logic                 r_stopReq;
  logic                 r_txReqByte;
  logic                 r_txReqBit;
  logic [DataWidth-1:0] r_txValue;
  logic                 r_rxReqByte;
  logic                 r_rxReqBit;
  logic                 r_respValid;

  logic                 w_bcastReq;
  logic [LenWidth-1:0]  w_countNext;

`ifdef I3C_CTRL_BCAST_HDR_EN
  assign w_bcastReq = bus.cmd_bcast_i;
`else
  // Header disabled: the input is deliberately masked so BCAST is unreachable
  assign w_bcastReq = 1'b0 & bus.cmd_bcast_i;
`endif

  // Byte counter saturates instead of wrapping back to zero
  assign w_countNext = (r_count == {LenWidth{1'b1}}) ? r_count
                                                     : r_count + LenWidth'(1);

  // Single sequencer: every bus request is raised one cycle after its state
  // is entered, held until the matching done, and dropped on that done.
  // Done inputs are only looked at while the matching request is high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= ST_IDLE;
      r_addr         <= '0;
      r_rnw          <= 1'b0;
      r_len          <= '0;
      r_bcast        <= 1'b0;
      r_tbit         <= 1'b0;
      r_count        <= '0;
      r_status       <= STATUS_OK;
      r_cmdReady     <= 1'b1;
      r_idle         <= 1'b1;
      r_txFifoRready <= 1'b0;
      r_rxFifoWvalid <= 1'b0;
      r_rxFifoWdata  <= '0;
      r_startReq     <= 1'b0;
      r_stopReq      <= 1'b0;
      r_txReqByte    <= 1'b0;
      r_txReqBit     <= 1'b0;
      r_txValue      <= '0;
      r_rxReqByte    <= 1'b0;
      r_rxReqBit     <= 1'b0;
      r_respValid    <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid_i) begin
            r_addr     <= bus.cmd_addr_i;
            r_rnw      <= bus.cmd_rnw_i;
            r_len      <= bus.cmd_len_i;
            r_bcast    <= w_bcastReq;
            r_count    <= '0;
            r_status   <= STATUS_OK;
            r_cmdReady <= 1'b0;
            r_idle     <= 1'b0;
            r_state    <= ST_START;
          end
        end

        ST_START, ST_RSTART: begin
          if (!r_startReq) begin
            r_startReq <= 1'b1;
          end else if (bus.bus_start_done_i) begin
            r_startReq <= 1'b0;
            // Only the first START can lead into the broadcast header
            r_state    <= (r_state == ST_START && r_bcast) ? ST_BCAST : ST_ADDR;
          end
        end

        ST_BCAST: begin
          if (!r_txReqByte) begin
            r_txReqByte <= 1'b1;
            r_txValue   <= DataWidth'({7'h7E, 1'b0});
          end else if (bus.bus_tx_done_i) begin
            r_txReqByte <= 1'b0;
            r_state     <= ST_BCAST_ACK;
          end
        end

        ST_BCAST_ACK: begin
          if (!r_rxReqBit) begin
            r_rxReqBit <= 1'b1;
          end else if (bus.bus_rx_done_i) begin
            r_rxReqBit <= 1'b0;
            if (bus.bus_rx_data_i[0]) begin
              r_status <= STATUS_BCAST_NACK;
              r_state  <= ST_STOP;
            end else begin
              r_state  <= ST_RSTART;
            end
          end
        end

        ST_ADDR: begin
          if (!r_txReqByte) begin
            r_txReqByte <= 1'b1;
            r_txValue   <= DataWidth'({r_addr, r_rnw});
          end else if (bus.bus_tx_done_i) begin
            r_txReqByte <= 1'b0;
            r_state     <= ST_ADDR_ACK;
          end
        end

        ST_ADDR_ACK: begin
          if (!r_rxReqBit) begin
            r_rxReqBit <= 1'b1;
          end else if (bus.bus_rx_done_i) begin
            r_rxReqBit <= 1'b0;
            if (bus.bus_rx_data_i[0]) begin
              r_status <= STATUS_ADDR_NACK;
              r_state  <= ST_STOP;
            end else if (r_len == '0) begin
              r_state  <= ST_STOP;
            end else begin
              r_state  <= r_rnw ? ST_RDATA : ST_WDATA;
            end
          end
        end

        // Pop is a one-cycle rready pulse; the byte is captured in that same
        // handshake cycle. With no data available SCL simply stays low.
        ST_WDATA: begin
          if (r_txFifoRready) begin
            r_txFifoRready <= 1'b0;
            r_txValue      <= bus.tx_fifo_rdata_i;
            r_txReqByte    <= 1'b1;
          end else if (r_txReqByte) begin
            if (bus.bus_tx_done_i) begin
              r_txReqByte <= 1'b0;
              r_tbit      <= ~^r_txValue;
              r_state     <= ST_WPAR;
            end
          end else if (bus.tx_fifo_rvalid_i) begin
            r_txFifoRready <= 1'b1;
          end
        end

        ST_WPAR: begin
          if (!r_txReqBit) begin
            r_txReqBit <= 1'b1;
            r_txValue  <= {{(DataWidth-1){1'b0}}, r_tbit};
          end else if (bus.bus_tx_done_i) begin
            r_txReqBit <= 1'b0;
            r_count    <= w_countNext;
            r_state    <= (w_countNext == r_len) ? ST_STOP : ST_WDATA;
          end
        end

        // The push is offered on the same edge the byte arrives, so a sink
        // that is already ready takes it in a single RPUSH cycle
        ST_RDATA: begin
          if (!r_rxReqByte) begin
            r_rxReqByte <= 1'b1;
          end else if (bus.bus_rx_done_i) begin
            r_rxReqByte    <= 1'b0;
            r_rxFifoWdata  <= bus.bus_rx_data_i;
            r_rxFifoWvalid <= 1'b1;
            r_state        <= ST_RPUSH;
          end
        end

        ST_RPUSH: begin
          if (bus.rx_fifo_wready_i) begin
            r_rxFifoWvalid <= 1'b0;
            r_count        <= w_countNext;
            r_state        <= ST_RTBIT;
          end
        end

        // Reaching the requested length ends the read regardless of T
        ST_RTBIT: begin
          if (!r_rxReqBit) begin
            r_rxReqBit <= 1'b1;
          end else if (bus.bus_rx_done_i) begin
            r_rxReqBit <= 1'b0;
            if (r_count == r_len) begin
              r_state  <= ST_STOP;
            end else if (!bus.bus_rx_data_i[0]) begin
              r_status <= STATUS_EARLY_END;
              r_state  <= ST_STOP;
            end else begin
              r_state  <= ST_RDATA;
            end
          end
        end

        ST_STOP: begin
          if (!r_stopReq) begin
            r_stopReq <= 1'b1;
          end else if (bus.bus_stop_done_i) begin
            r_stopReq   <= 1'b0;
            r_respValid <= 1'b1;
            r_state     <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (bus.resp_ready_i) begin
            r_respValid <= 1'b0;
            r_cmdReady  <= 1'b1;
            r_idle      <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready_o        = r_cmdReady;
  assign bus.idle_o             = r_idle;
  assign bus.tx_fifo_rready_o   = r_txFifoRready;
  assign bus.rx_fifo_wvalid_o   = r_rxFifoWvalid;
  assign bus.rx_fifo_wdata_o    = r_rxFifoWdata;
  assign bus.bus_start_req_o    = r_startReq;
  assign bus.bus_stop_req_o     = r_stopReq;
  assign bus.bus_tx_req_byte_o  = r_txReqByte;
  assign bus.bus_tx_req_bit_o   = r_txReqBit;
  assign bus.bus_tx_req_value_o = r_txValue;
  assign bus.bus_rx_req_byte_o  = r_rxReqByte;
  assign bus.bus_rx_req_bit_o   = r_rxReqBit;
  assign bus.resp_valid_o       = r_respValid;
  assign bus.resp_status_o      = r_status;
  assign bus.resp_count_o       = r_count;

endmodule

// File: tb/tb_i3c_controller_sdr_fsm.sv
// ---------------------------------------------------------------------------
// tb_i3c_controller_sdr_fsm
//   Directed bench for the controller SDR sequencer. The initial block plays
//   the command queue, the FIFOs and the bus primitive layer step by step and
//   checks each bus request, value and response against hand-computed values.
// ---------------------------------------------------------------------------
module tb_i3c_controller_sdr_fsm;
  localparam int DW = 8;
  localparam int LW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int errors    = 0;
  int checks    = 0;
  int popCount  = 0;
  int pushCount = 0;
  logic [7:0] pushData [16];

  // Free-running clock, 10 ns period
  always #5 clk = ~clk;

  i3c_controller_sdr_fsm_if #(.DataWidth(DW), .LenWidth(LW)) ifc ();

  i3c_controller_sdr_fsm #(.DataWidth(DW), .LenWidth(LW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (ifc)
  );

  // Records every TX FIFO pop and RX FIFO push that actually handshakes
  always @(posedge clk) begin
    if (rst_n && ifc.tx_fifo_rvalid_i && ifc.tx_fifo_rready_o)
      popCount <= popCount + 1;
    if (rst_n && ifc.rx_fifo_wvalid_o && ifc.rx_fifo_wready_i) begin
      pushData[pushCount[3:0]] <= ifc.rx_fifo_wdata_o;
      pushCount <= pushCount + 1;
    end
  end

  // Last-resort guard so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [5:0] reqVec();
    return {ifc.bus_start_req_o, ifc.bus_stop_req_o, ifc.bus_tx_req_byte_o,
            ifc.bus_tx_req_bit_o, ifc.bus_rx_req_byte_o, ifc.bus_rx_req_bit_o};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Request index: 5 start, 4 stop, 3 txByte, 2 txBit, 1 rxByte, 0 rxBit
  task automatic waitReq(input string tag, input int idx);
    logic [5:0] v;
    bit found;
    found = 1'b0;
    v = reqVec();
    for (int i = 0; i < 60; i++) begin
      v = reqVec();
      if (v[idx]) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput({tag, "_req"}, 32'(found), 32'd1);
    if (found) checkOutput({tag, "_onehot"}, 32'($countones(v)), 32'd1);
  endtask

  task automatic applyStimulus(input logic [6:0] addr, input logic rnw,
                               input logic [7:0] len, input logic bcast);
    ifc.cmd_addr_i  = addr;
    ifc.cmd_rnw_i   = rnw;
    ifc.cmd_len_i   = len;
    ifc.cmd_bcast_i = bcast;
    ifc.cmd_valid_i = 1'b1;
    @(negedge clk);
    ifc.cmd_valid_i = 1'b0;
    checkOutput("accept_ready", 32'(ifc.cmd_ready_o), 32'd0);
  endtask

  task automatic busStart(input string tag);
    waitReq(tag, 5);
    ifc.bus_start_done_i = 1'b1;
    @(negedge clk);
    ifc.bus_start_done_i = 1'b0;
    checkOutput({tag, "_drop"}, 32'(ifc.bus_start_req_o), 32'd0);
  endtask

  task automatic busTx(input string tag, input bit isBit, input logic [7:0] value);
    waitReq(tag, isBit ? 2 : 3);
    if (isBit) checkOutput({tag, "_val"}, 32'(ifc.bus_tx_req_value_o[0]), 32'(value));
    else       checkOutput({tag, "_val"}, 32'(ifc.bus_tx_req_value_o), 32'(value));
    ifc.bus_tx_done_i = 1'b1;
    @(negedge clk);
    ifc.bus_tx_done_i = 1'b0;
    checkOutput({tag, "_drop"}, 32'(ifc.bus_tx_req_byte_o | ifc.bus_tx_req_bit_o), 32'd0);
  endtask

  task automatic busRx(input string tag, input bit isBit, input logic [7:0] value);
    waitReq(tag, isBit ? 0 : 1);
    ifc.bus_rx_data_i = value;
    ifc.bus_rx_done_i = 1'b1;
    @(negedge clk);
    ifc.bus_rx_done_i = 1'b0;
    checkOutput({tag, "_drop"}, 32'(ifc.bus_rx_req_byte_o | ifc.bus_rx_req_bit_o), 32'd0);
  endtask

  task automatic busStop(input string tag);
    waitReq(tag, 4);
    ifc.bus_stop_done_i = 1'b1;
    @(negedge clk);
    ifc.bus_stop_done_i = 1'b0;
    checkOutput({tag, "_drop"}, 32'(ifc.bus_stop_req_o), 32'd0);
    checkOutput({tag, "_respLatency"}, 32'(ifc.resp_valid_o), 32'd1);
  endtask

  task automatic waitResp(input string tag, input logic [1:0] status,
                          input logic [7:0] count);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ifc.resp_valid_o) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput({tag, "_respValid"}, 32'(found), 32'd1);
    checkOutput({tag, "_status"}, 32'(ifc.resp_status_o), 32'(status));
    checkOutput({tag, "_count"}, 32'(ifc.resp_count_o), 32'(count));
    checkOutput({tag, "_readyInResp"}, 32'(ifc.cmd_ready_o), 32'd0);
    ifc.resp_ready_i = 1'b1;
    @(negedge clk);
    ifc.resp_ready_i = 1'b0;
    checkOutput({tag, "_respDrop"}, 32'(ifc.resp_valid_o), 32'd0);
    checkOutput({tag, "_idle"}, 32'({ifc.idle_o, ifc.cmd_ready_o}), 32'd3);
  endtask

  task automatic provideTx(input string tag, input logic [7:0] data);
    bit found;
    found = 1'b0;
    ifc.tx_fifo_rdata_i  = data;
    ifc.tx_fifo_rvalid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifc.tx_fifo_rready_o) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_pop"}, 32'(found), 32'd1);
    @(negedge clk);
    ifc.tx_fifo_rvalid_i = 1'b0;
  endtask

  task automatic stallCheck(input string tag, input int n);
    bit anyReq;
    anyReq = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (|reqVec()) anyReq = 1'b1;
    end
    checkOutput(tag, 32'(anyReq), 32'd0);
  endtask

  initial begin
    int popBase;
    int pushBase;
    ifc.cmd_valid_i      = 1'b0;
    ifc.cmd_addr_i       = '0;
    ifc.cmd_rnw_i        = 1'b0;
    ifc.cmd_len_i        = '0;
    ifc.cmd_bcast_i      = 1'b0;
    ifc.tx_fifo_rvalid_i = 1'b0;
    ifc.tx_fifo_rdata_i  = '0;
    ifc.rx_fifo_wready_i = 1'b1;
    ifc.bus_start_done_i = 1'b0;
    ifc.bus_stop_done_i  = 1'b0;
    ifc.bus_tx_done_i    = 1'b0;
    ifc.bus_rx_done_i    = 1'b0;
    ifc.bus_rx_data_i    = '0;
    ifc.resp_ready_i     = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_idle", 32'({ifc.idle_o, ifc.cmd_ready_o}), 32'd3);
    checkOutput("rst_reqs", 32'(reqVec()), 32'd0);
    checkOutput("rst_misc", 32'({ifc.resp_valid_o, ifc.tx_fifo_rready_o,
                                 ifc.rx_fifo_wvalid_o}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Stray done with no request pending must not disturb IDLE
    ifc.bus_tx_done_i = 1'b1;
    @(negedge clk);
    ifc.bus_tx_done_i = 1'b0;
    checkOutput("stray_done", 32'({ifc.idle_o, reqVec()}), 32'h40);

    // Write 0x5A, 2 bytes (0x01 -> T=0, 0x03 -> T=1) with a 10-cycle FIFO gap
    popBase = popCount;
    applyStimulus(7'h5A, 1'b0, 8'd2, 1'b0);
    busStart("wr_start");
    busTx("wr_addr", 1'b0, 8'hB4);
    busRx("wr_ack", 1'b1, 8'h00);
    provideTx("wr_d0", 8'h01);
    busTx("wr_b0", 1'b0, 8'h01);
    busTx("wr_t0", 1'b1, 8'h00);
    stallCheck("wr_stall", 10);
    provideTx("wr_d1", 8'h03);
    busTx("wr_b1", 1'b0, 8'h03);
    busTx("wr_t1", 1'b1, 8'h01);
    busStop("wr_stop");
    waitResp("wr", 2'd0, 8'd2);
    checkOutput("wr_pops", 32'(popCount - popBase), 32'd2);

    // Read 0x12, 3 bytes, all T=1, sink stalls 5 cycles on the second push
    pushBase = pushCount;
    applyStimulus(7'h12, 1'b1, 8'd3, 1'b0);
    busStart("rd_start");
    busTx("rd_addr", 1'b0, 8'h25);
    busRx("rd_ack", 1'b1, 8'h00);
    busRx("rd_b0", 1'b0, 8'hA1);
    busRx("rd_t0", 1'b1, 8'h01);
    ifc.rx_fifo_wready_i = 1'b0;
    busRx("rd_b1", 1'b0, 8'hB2);
    stallCheck("rd_stall", 5);
    checkOutput("rd_wvalidHeld", 32'(ifc.rx_fifo_wvalid_o), 32'd1);
    checkOutput("rd_pushHeld", 32'(pushCount - pushBase), 32'd1);
    ifc.rx_fifo_wready_i = 1'b1;
    busRx("rd_t1", 1'b1, 8'h01);
    busRx("rd_b2", 1'b0, 8'hC3);
    busRx("rd_t2", 1'b1, 8'h01);
    busStop("rd_stop");
    waitResp("rd", 2'd0, 8'd3);
    checkOutput("rd_pushes", 32'(pushCount - pushBase), 32'd3);
    checkOutput("rd_data", {8'h00, pushData[pushBase[3:0]],
                            pushData[4'(pushBase + 1)], pushData[4'(pushBase + 2)]},
                32'h00A1B2C3);

    // Read 0x33, 4 bytes, target ends early with T=0 after byte 2
    pushBase = pushCount;
    applyStimulus(7'h33, 1'b1, 8'd4, 1'b0);
    busStart("early_start");
    busTx("early_addr", 1'b0, 8'h67);
    busRx("early_ack", 1'b1, 8'h00);
    busRx("early_b0", 1'b0, 8'h11);
    busRx("early_t0", 1'b1, 8'h01);
    busRx("early_b1", 1'b0, 8'h22);
    busRx("early_t1", 1'b1, 8'h00);
    busStop("early_stop");
    waitResp("early", 2'd2, 8'd2);
    checkOutput("early_pushes", 32'(pushCount - pushBase), 32'd2);

    // Address NACK on a write of 5: data waiting in the FIFO must stay there
    popBase = popCount;
    ifc.tx_fifo_rdata_i  = 8'hEE;
    ifc.tx_fifo_rvalid_i = 1'b1;
    applyStimulus(7'h40, 1'b0, 8'd5, 1'b0);
    busStart("nack_start");
    busTx("nack_addr", 1'b0, 8'h80);
    busRx("nack_ack", 1'b1, 8'h01);
    busStop("nack_stop");
    waitResp("nack", 2'd1, 8'd0);
    checkOutput("nack_pops", 32'(popCount - popBase), 32'd0);
    ifc.tx_fifo_rvalid_i = 1'b0;

    // Address-only write (len 0)
    applyStimulus(7'h10, 1'b0, 8'd0, 1'b0);
    busStart("a0_start");
    busTx("a0_addr", 1'b0, 8'h20);
    busRx("a0_ack", 1'b1, 8'h00);
    busStop("a0_stop");
    waitResp("a0", 2'd0, 8'd0);

`ifdef I3C_CTRL_BCAST_HDR_EN
    // Broadcast header acknowledged, then repeated START and address
    applyStimulus(7'h5A, 1'b0, 8'd0, 1'b1);
    busStart("bc_start");
    busTx("bc_hdr", 1'b0, 8'hFC);
    busRx("bc_hack", 1'b1, 8'h00);
    busStart("bc_rstart");
    busTx("bc_addr", 1'b0, 8'hB4);
    busRx("bc_ack", 1'b1, 8'h00);
    busStop("bc_stop");
    waitResp("bc", 2'd0, 8'd0);

    // Broadcast header NACK
    applyStimulus(7'h5A, 1'b0, 8'd1, 1'b1);
    busStart("bcn_start");
    busTx("bcn_hdr", 1'b0, 8'hFC);
    busRx("bcn_hack", 1'b1, 8'h01);
    busStop("bcn_stop");
    waitResp("bcn", 2'd3, 8'd0);
`else
    // Header request is ignored: the first byte after START is the address
    applyStimulus(7'h5A, 1'b0, 8'd0, 1'b1);
    busStart("bc_start");
    busTx("bc_addr", 1'b0, 8'hB4);
    busRx("bc_ack", 1'b1, 8'h00);
    busStop("bc_stop");
    waitResp("bc", 2'd0, 8'd0);
`endif

    // Reset while an RX byte is in flight: immediate IDLE, no STOP, no response
    applyStimulus(7'h12, 1'b1, 8'd1, 1'b0);
    busStart("rst_start");
    busTx("rst_addr", 1'b0, 8'h25);
    busRx("rst_ack", 1'b1, 8'h00);
    waitReq("rst_byte", 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_idle", 32'({ifc.idle_o, ifc.cmd_ready_o}), 32'd3);
    checkOutput("midrst_reqs", 32'(reqVec()), 32'd0);
    checkOutput("midrst_resp", 32'({ifc.resp_valid_o, ifc.rx_fifo_wvalid_o}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stallCheck("postrst_quiet", 5);
    checkOutput("postrst_resp", 32'(ifc.resp_valid_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
